ex_mem_skid_reg: RTL
====================

EX_MEM_SKID_REG -- requirements
Module: ex_mem_skid_reg

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1; valid/ready handshake from Execute.
REQ-004 SHALL have input payload: in_pc 32, in_inst 32, in_rw_en 1, in_rw_addr 5, in_ex_result 32, in_lsu_op 4, in_lsu_data 32.
REQ-005 SHALL have ports: out_valid output 1, out_ready input 1; valid/ready handshake to MemoryAccess.
REQ-006 SHALL have output payload with the same names and widths as REQ-004 (out_ prefix), plus out_ale output 1 (address-misaligned flag).
REQ-007 SHALL have port: flush input 1, which kills all held entries.

Function
REQ-008 SHALL hold two entries: main (drives out_*) and skid (catches a beat accepted while main is stalled).
REQ-009 SHALL assert in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
REQ-010 SHALL assert out_valid = main_valid; out_* SHALL come directly from main registers.
REQ-011 SHALL accept input on in_valid && in_ready and release output on out_valid && out_ready.
REQ-012 SHALL load an accepted beat into main if main is empty or main releases in the same cycle; otherwise it SHALL load it into skid.
REQ-013 SHALL move skid into main when main releases and skid is full, in the same cycle; an input accepted in that cycle is impossible because in_ready=0.
REQ-014 SHALL give one-cycle latency: a beat accepted in cycle N is visible on out_* in cycle N+1 when main was free.
REQ-015 SHALL preserve order; no beat may be lost, duplicated or reordered under any out_ready pattern.
REQ-016 SHALL compute ale at capture: lsu_op LD.H/LD.HU/ST.H (0001/1001/0101) with ex_result[0]=1, or LD.W/ST.W (0010/0110) with ex_result[1:0]!=0.
REQ-017 SHALL, on ale=1, store lsu_op=4'b1111 (no memory access) and rw_en=0, and keep pc, inst and ex_result unchanged.
REQ-018 SHALL, when flush=1, clear main_valid and skid_valid at the next edge and ignore any beat accepted that cycle; flush overrides every other event.
REQ-019 SHALL not update payload registers when their entry is not loaded (hold value; no X propagation).

Reset
REQ-020 SHALL, while rst_n=0, force main_valid=0, skid_valid=0, out_valid=0, in_ready=1, out_ale=0, out_rw_en=0, out_lsu_op=4'b1111, and all other payload outputs to 0.
REQ-021 SHALL drop any in-flight beats on reset assertion mid-operation and accept input in the first cycle after release.

Structure
REQ-022 SHALL take the ex_mem payload struct, the LSU_* opcode constants (including LSU_NOP=4'b1111), and the width parameters from the shared package pipe_pkg.
REQ-023 SHALL place misalignment detection and op squashing (REQ-016/017) in the combinational sub-module lsu_align_check, instantiated once on the input path.

Verification
REQ-024 Stream: 8 beats, out_ready=1 always -> each beat appears 1 cycle later; in_ready stays 1; order matches.
REQ-025 Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> main holds beat A, skid takes B, in_ready=0; on out_ready=1 the outputs are A then B, then C, with no loss.
REQ-026 Misalignment: ST.W with ex_result=0x1C000002 -> out_ale=1, out_lsu_op=1111, out_rw_en=0; LD.H at 0x1C000002 -> out_ale=0, op unchanged.
REQ-027 Flush with both entries full and in_valid=1 -> the next cycle shows out_valid=0, in_ready=1, and the flushed beats never appear.
REQ-028 Async reset: assert rst_n=0 mid-cycle with skid full -> outputs reach reset values immediately without waiting for a clock edge; a beat offered after release emerges 1 cycle later.
REQ-029 Random: random in_valid/out_ready at 50% for 10k cycles, checked against a scoreboard FIFO -> no mismatch, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants: ex_mem payload, LSU opcodes, width parameters.
// Also holds the alignment rule used when a beat is captured into the EX/MEM stage.
package pipe_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int LSU_OP_W   = 4;

  localparam logic [LSU_OP_W-1:0] LSU_LD_B  = 4'b0000;
  localparam logic [LSU_OP_W-1:0] LSU_LD_H  = 4'b0001;
  localparam logic [LSU_OP_W-1:0] LSU_LD_W  = 4'b0010;
  localparam logic [LSU_OP_W-1:0] LSU_ST_B  = 4'b0100;
  localparam logic [LSU_OP_W-1:0] LSU_ST_H  = 4'b0101;
  localparam logic [LSU_OP_W-1:0] LSU_ST_W  = 4'b0110;
  localparam logic [LSU_OP_W-1:0] LSU_LD_BU = 4'b1000;
  localparam logic [LSU_OP_W-1:0] LSU_LD_HU = 4'b1001;
  localparam logic [LSU_OP_W-1:0] LSU_NOP   = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       inst;
    logic                  rw_en;
    logic [REG_ADDR_W-1:0] rw_addr;
    logic [XLEN-1:0]       ex_result;
    logic [LSU_OP_W-1:0]   lsu_op;
    logic [XLEN-1:0]       lsu_data;
    logic                  ale;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_RESET = '{
    pc:        32'h0000_0000,
    inst:      32'h0000_0000,
    rw_en:     1'b0,
    rw_addr:   5'd0,
    ex_result: 32'h0000_0000,
    lsu_op:    LSU_NOP,
    lsu_data:  32'h0000_0000,
    ale:       1'b0
  };

  // Halfword accesses need bit 0 clear, word accesses need bits [1:0] clear.
  function automatic logic lsu_misaligned(input logic [LSU_OP_W-1:0] op,
                                          input logic [1:0]          addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      LSU_LD_H, LSU_LD_HU, LSU_ST_H: mis = addr_lo[0];
      LSU_LD_W, LSU_ST_W:            mis = (addr_lo != 2'b00);
      default:                       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational misalignment check on the EX/MEM capture path.
// A misaligned access is squashed into a no-memory, no-writeback operation.
module lsu_align_check
  import pipe_pkg::*;
(
  input  logic [LSU_OP_W-1:0] lsu_op_i,
  input  logic [1:0]          addr_lo_i,
  input  logic                rw_en_i,
  output logic                ale_o,
  output logic [LSU_OP_W-1:0] lsu_op_o,
  output logic                rw_en_o
);

  logic ale_s;

  // Flag the access and replace op/writeback when misaligned.
  always_comb begin
    ale_s    = lsu_misaligned(lsu_op_i, addr_lo_i);
    lsu_op_o = lsu_op_i;
    rw_en_o  = rw_en_i;
    if (ale_s) begin
      lsu_op_o = LSU_NOP;
      rw_en_o  = 1'b0;
    end else begin
      lsu_op_o = lsu_op_i;
      rw_en_o  = rw_en_i;
    end
    ale_o = ale_s;
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid).
// in_ready is a pure register output so no combinational path exists from out_ready.
module ex_mem_skid_reg
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_inst,
  input  logic                  in_rw_en,
  input  logic [REG_ADDR_W-1:0] in_rw_addr,
  input  logic [XLEN-1:0]       in_ex_result,
  input  logic [LSU_OP_W-1:0]   in_lsu_op,
  input  logic [XLEN-1:0]       in_lsu_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_inst,
  output logic                  out_rw_en,
  output logic [REG_ADDR_W-1:0] out_rw_addr,
  output logic [XLEN-1:0]       out_ex_result,
  output logic [LSU_OP_W-1:0]   out_lsu_op,
  output logic [XLEN-1:0]       out_lsu_data,
  output logic                  out_ale
);

  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  ex_mem_t main_q, main_d;
  ex_mem_t skid_q, skid_d;
  ex_mem_t in_beat_s;
  logic    accept_s, release_s;
  logic    ale_s, rw_en_s;
  logic [LSU_OP_W-1:0] lsu_op_s;

  lsu_align_check u_align (
    .lsu_op_i  (in_lsu_op),
    .addr_lo_i (in_ex_result[1:0]),
    .rw_en_i   (in_rw_en),
    .ale_o     (ale_s),
    .lsu_op_o  (lsu_op_s),
    .rw_en_o   (rw_en_s)
  );

  assign in_beat_s = '{
    pc:        in_pc,
    inst:      in_inst,
    rw_en:     rw_en_s,
    rw_addr:   in_rw_addr,
    ex_result: in_ex_result,
    lsu_op:    lsu_op_s,
    lsu_data:  in_lsu_data,
    ale:       ale_s
  };

  assign accept_s  = in_valid && !skid_valid_q;
  assign release_s = main_valid_q && out_ready;

  // Next-state for both entries; flush wins, then skid->main refill, then capture.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (release_s && skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept_s && (release_s || !main_valid_q)) begin
      main_d       = in_beat_s;
      main_valid_d = 1'b1;
    end else if (accept_s) begin
      skid_d       = in_beat_s;
      skid_valid_d = 1'b1;
    end else if (release_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers; payloads reset to a harmless no-op beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= EX_MEM_RESET;
      skid_q       <= EX_MEM_RESET;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready      = !skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_pc        = main_q.pc;
  assign out_inst      = main_q.inst;
  assign out_rw_en     = main_q.rw_en;
  assign out_rw_addr   = main_q.rw_addr;
  assign out_ex_result = main_q.ex_result;
  assign out_lsu_op    = main_q.lsu_op;
  assign out_lsu_data  = main_q.lsu_data;
  assign out_ale       = main_q.ale;

endmodule
